// File: rtl/out_display.sv
// BCD display driver: double-dabble conversion (WIDTH+1 cycles after capture) feeding a multiplexed 7-segment scan.
// No backpressure: input changes during a conversion are picked up by the next IDLE compare.
module out_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_signed,
    output logic [6:0]        o_seg,
    output logic [DIGITS-1:0] o_digit_en,
    output logic              o_busy
);
    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int PW   = $clog2(REFRESH_DIV);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   cap_q, cap_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [BW-1:0]    disp_q, disp_d;
    logic             disp_neg_q, disp_neg_d;

    logic [PW-1:0]     presc_q;
    logic [IDXW-1:0]   idx_q;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] en_q;
    logic [IDXW-1:0]   msd;
    logic [3:0]        cur_nib;
    logic [6:0]        seg_pat;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        disp_d     = disp_q;
        disp_neg_d = disp_neg_q;
        case (state_q)
            IDLE: begin
                if ({i_signed, i_data} != cap_q) begin
                    cap_d   = {i_signed, i_data};
                    neg_d   = i_signed & i_data[WIDTH-1];
                    mag_d   = neg_d ? (~i_data + WIDTH'(1)) : i_data;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = LOAD;
            end
            LOAD: begin
                disp_d     = bcd_q;
                disp_neg_d = neg_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            disp_q     <= '0;
            disp_neg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            disp_q     <= disp_d;
            disp_neg_q <= disp_neg_d;
        end
    end

    // Minus sits one place left of the most significant nonzero digit; digit 0 always lit.
    always_comb begin
        msd = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (disp_q[4*k +: 4] != 4'd0)
                msd = IDXW'(k);
        end
        cur_nib = disp_q[4*idx_q +: 4];
        if (idx_q <= msd)
            seg_pat = seg_of(cur_nib);
        else if (disp_neg_q && (idx_q == msd + IDXW'(1)))
            seg_pat = 7'h40;
        else
            seg_pat = 7'h00;
    end

    // Outputs reload only at the start of a slot so a digit never changes mid-slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h3F;
            en_q    <= DIGITS'(1);
        end else begin
            if (presc_q == PW'(REFRESH_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            if (presc_q == '0) begin
                seg_q <= seg_pat;
                en_q  <= DIGITS'(1) << idx_q;
            end
        end
    end

    assign o_seg      = seg_q;
    assign o_digit_en = en_q;
    assign o_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_out_display.sv
module tb_out_display;
    localparam int W = 8;
    localparam int D = 4;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_data;
    logic         i_signed;
    logic [6:0]   o_seg;
    logic [D-1:0] o_digit_en;
    logic         o_busy;

    int checks = 0;
    int errors = 0;

    out_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_signed(i_signed),
        .o_seg(o_seg), .o_digit_en(o_digit_en), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] pat(input int n);
        logic [6:0] lut [10];
        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return lut[n];
    endfunction

    // Reference: decimal rendering of the value with blanking and a leading minus.
    function automatic logic [D-1:0][6:0] model(input logic [W-1:0] d, input logic s);
        logic [D-1:0][6:0] e;
        int v, mag, nd, m;
        bit neg;
        v   = int'(d);
        neg = s && (v >= (1 << (W - 1)));
        mag = neg ? (1 << W) - v : v;
        nd  = 1;
        m   = mag / 10;
        while (m > 0) begin
            nd++;
            m = m / 10;
        end
        m = mag;
        for (int p = 0; p < D; p++) begin
            if (p < nd)               e[p] = pat(m % 10);
            else if (neg && p == nd)  e[p] = 7'h40;
            else                      e[p] = 7'h00;
            m = m / 10;
        end
        return e;
    endfunction

    function automatic int idx_of(input logic [D-1:0] en);
        if (!$onehot(en)) return -1;
        for (int i = 0; i < D; i++) if (en[i]) return i;
        return -1;
    endfunction

    task automatic apply(input logic [W-1:0] d, input logic s, output int hi);
        bit started;
        @(negedge clk);
        i_data   = d;
        i_signed = s;
        hi       = 0;
        started  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_busy) begin
                hi++;
                started = 1;
            end else if (started) begin
                break;
            end
        end
    endtask

    task automatic check_display(input string tag, input logic [W-1:0] d, input logic s);
        logic [D-1:0][6:0] e;
        logic [6:0] obs [D];
        bit seen [D];
        int bad_en, ix;
        e = model(d, s);
        bad_en = 0;
        for (int i = 0; i < D; i++) begin
            seen[i] = 0;
            obs[i]  = 7'h7F;
        end
        repeat (D * R + 4) @(negedge clk);
        for (int c = 0; c < 2 * D * R; c++) begin
            @(negedge clk);
            ix = idx_of(o_digit_en);
            if (ix < 0) bad_en++;
            else begin
                obs[ix]  = o_seg;
                seen[ix] = 1;
            end
        end
        chk({tag, "_onehot"}, bad_en, 0);
        for (int i = 0; i < D; i++)
            chk($sformatf("%s_dig%0d", tag, i), seen[i] ? int'(obs[i]) : -1, int'(e[i]));
    endtask

    task automatic check_scan();
        int prev, cur, run, tr, runs_bad, order_bad, wraps;
        prev = -1; run = 0; tr = 0; runs_bad = 0; order_bad = 0; wraps = 0;
        for (int c = 0; c < 12 * R; c++) begin
            @(negedge clk);
            cur = idx_of(o_digit_en);
            if (prev < 0) begin
                prev = cur;
                run  = 1;
            end else if (cur == prev) begin
                run++;
            end else begin
                if (tr > 0 && run != R) runs_bad++;
                if (cur != (prev + 1) % D) order_bad++;
                if (prev == D - 1 && cur == 0) wraps++;
                tr++;
                prev = cur;
                run  = 1;
            end
        end
        chk("scan_hold", runs_bad, 0);
        chk("scan_order", order_bad, 0);
        chk("scan_wrap", int'(wraps > 0), 1);
    endtask

    initial begin
        int hi, busy_seen;
        int trace [40];
        logic [W-1:0] rd, last_d;
        logic rs, last_s;

        rst = 1'b1; i_data = '0; i_signed = 1'b0;
        @(negedge clk);
        chk("rst_seg", int'(o_seg), 'h3F);
        chk("rst_en", int'(o_digit_en), 1);
        chk("rst_busy", int'(o_busy), 0);
        rst = 1'b0;
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_busy) busy_seen++;
        end
        chk("rst_busy_never", busy_seen, 0);
        check_display("zero", 8'h00, 1'b0);

        apply(8'hFF, 1'b0, hi);
        chk("u255_busy", hi, W + 1);
        check_display("u255", 8'hFF, 1'b0);
        check_scan();

        apply(8'h80, 1'b1, hi);
        chk("sm128_busy", hi, W + 1);
        check_display("sm128", 8'h80, 1'b1);

        apply(8'hFF, 1'b1, hi);
        chk("sm1_busy", hi, W + 1);
        check_display("sm1", 8'hFF, 1'b1);
        apply(8'hFF, 1'b0, hi);
        chk("tog_busy", hi, W + 1);
        check_display("tog255", 8'hFF, 1'b0);

        // Change lands inside the first conversion; two back-to-back windows expected.
        @(negedge clk);
        i_data = 8'h05; i_signed = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            trace[c] = int'(o_busy);
            if (c == 3) i_data = 8'h63;
        end
        hi = 0;
        for (int c = 0; c < W + 1; c++) hi += trace[c];
        chk("mid_first_win", hi, W + 1);
        chk("mid_gap", trace[W + 1], 0);
        hi = 0;
        for (int c = W + 2; c < 2 * W + 3; c++) hi += trace[c];
        chk("mid_second_win", hi, W + 1);
        chk("mid_end_idle", trace[2 * W + 3], 0);
        check_display("mid99", 8'h63, 1'b0);

        @(negedge clk);
        i_data = 8'h37;
        repeat (4) @(negedge clk);
        chk("rmid_busy_before", int'(o_busy), 1);
        rst = 1'b1;
        #1;
        chk("rmid_busy", int'(o_busy), 0);
        chk("rmid_seg", int'(o_seg), 'h3F);
        chk("rmid_en", int'(o_digit_en), 1);
        @(negedge clk);
        i_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_busy) busy_seen++;
        end
        chk("rmid_no_busy", busy_seen, 0);
        check_display("rmid_zero", 8'h00, 1'b0);

        last_d = 8'h00; last_s = 1'b0;
        for (int n = 0; n < 16; n++) begin
            do begin
                rd = W'($urandom_range(0, 255));
                rs = 1'($urandom_range(0, 1));
            end while (rd == last_d && rs == last_s);
            last_d = rd; last_s = rs;
            apply(rd, rs, hi);
            chk($sformatf("rnd%0d_busy", n), hi, W + 1);
            check_display($sformatf("rnd%0d", n), rd, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
